// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and core width constants used by the fetch path and its memories.
package ahb_pkg;

   localparam int unsigned PC_WIDTH   = 32;
   localparam int unsigned INST_WIDTH = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StErr1,
      StErr2
   } imem_state_e;

endpackage

// File: rtl/imem_ram_1r1w.sv
// Instruction array: synchronous bus read port, synchronous backdoor write port.
// A same-cycle read and write of one word returns the old contents.
module imem_ram_1r1w #(
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rd_en_i,
   input  logic [IDX_W-1:0]      rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   input  logic                  wr_en_i,
   input  logic [IDX_W-1:0]      wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Read register only updates on enable, so a word captured for a waited
   // transfer survives later backdoor writes.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ahb_imem_slave.sv
// AHB-Lite read-only instruction memory responder with configurable wait states,
// two-cycle ERROR responses and a backdoor load port.
module ahb_imem_slave
   import ahb_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = PC_WIDTH,
   parameter int unsigned           DATA_WIDTH  = INST_WIDTH,
   parameter int unsigned           DEPTH       = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned           WAIT_STATES = 0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     hsel_i,
   input  logic [ADDR_WIDTH-1:0]    haddr_i,
   input  logic [1:0]               htrans_i,
   input  logic                     hwrite_i,
   input  logic [2:0]               hsize_i,
   input  logic [2:0]               hburst_i,
   input  logic                     hready_i,
   output logic                     hreadyout_o,
   output logic                     hresp_o,
   output logic [DATA_WIDTH-1:0]    hrdata_o,
   input  logic                     load_en_i,
   input  logic [$clog2(DEPTH)-1:0] load_addr_i,
   input  logic [DATA_WIDTH-1:0]    load_data_i
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   imem_state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rd_pend_q, rd_pend_d;
   logic [DATA_WIDTH-1:0] hrdata_q;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic        rd_en;

   logic [ADDR_WIDTH-1:0] offset;
   logic                  addr_valid;
   logic                  illegal;

   assign offset     = haddr_i - BASE_ADDR;
   assign addr_valid = hsel_i & hready_i & htrans_i[1];
   assign illegal    = hwrite_i | (hsize_i != HSIZE_WORD) | (haddr_i[1:0] != 2'b00) |
                       (|offset[ADDR_WIDTH-1:IDX_W+2]);

   logic unused_bits;
   assign unused_bits = ^{hburst_i, htrans_i[0], offset[1:0]};

   imem_ram_1r1w #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_ram (
      .clk_i     (clk_i),
      .rd_en_i   (rd_en),
      .rd_addr_i (offset[IDX_W+1:2]),
      .rd_data_o (ram_rdata),
      .wr_en_i   (load_en_i),
      .wr_addr_i (load_addr_i),
      .wr_data_i (load_data_i)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rd_pend_d   = 1'b0;
      rd_en       = 1'b0;
      hreadyout_o = 1'b1;
      hresp_o     = HRESP_OKAY;
      case (state_q)
         StIdle, StErr2: begin
            if (state_q == StErr2) begin
               hresp_o = HRESP_ERROR;
            end
            state_d = StIdle;
            if (addr_valid) begin
               if (illegal) begin
                  state_d = StErr1;
               end else begin
                  rd_en = 1'b1;
                  if (WAIT_STATES == 0) begin
                     rd_pend_d = 1'b1;
                  end else begin
                     state_d = StWait;
                     cnt_d   = 4'(WAIT_STATES);
                  end
               end
            end
         end
         StWait: begin
            hreadyout_o = 1'b0;
            cnt_d       = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d   = StIdle;
               rd_pend_d = 1'b1;
            end
         end
         StErr1: begin
            hreadyout_o = 1'b0;
            hresp_o     = HRESP_ERROR;
            state_d     = StErr2;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rd_pend_q <= 1'b0;
         hrdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= rd_pend_d;
         if (state_q == StErr2) begin
            hrdata_q <= '0;
         end else if (rd_pend_q) begin
            hrdata_q <= ram_rdata;
         end
      end
   end

   // Completing reads show the RAM register directly; otherwise hold the last value.
   always_comb begin
      if (state_q == StErr2) begin
         hrdata_o = '0;
      end else if (rd_pend_q) begin
         hrdata_o = ram_rdata;
      end else begin
         hrdata_o = hrdata_q;
      end
   end

endmodule

// File: tb/tb_ahb_imem_slave.sv
// Directed bench: three responders (0, 3 and 2 wait states) share one bus and load port.
module tb_ahb_imem_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hsel = 1'b0;
   logic [31:0] haddr = '0;
   logic [1:0]  htrans = 2'b00;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'b010;
   logic [2:0]  hburst = 3'b000;
   logic        load_en = 1'b0;
   logic [9:0]  load_addr = '0;
   logic [31:0] load_data = '0;
   logic [1:0]  sel = 2'd0;

   logic [2:0]  rdy;
   logic [2:0]  rsp;
   logic [31:0] rd [3];
   logic        hready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign hready = rdy[sel];

   ahb_imem_slave #(.WAIT_STATES(0)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .hsel_i(hsel && sel == 2'd0), .haddr_i(haddr),
      .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst),
      .hready_i(hready), .hreadyout_o(rdy[0]), .hresp_o(rsp[0]), .hrdata_o(rd[0]),
      .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
   );

   ahb_imem_slave #(.WAIT_STATES(3)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .hsel_i(hsel && sel == 2'd1), .haddr_i(haddr),
      .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst),
      .hready_i(hready), .hreadyout_o(rdy[1]), .hresp_o(rsp[1]), .hrdata_o(rd[1]),
      .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
   );

   ahb_imem_slave #(.WAIT_STATES(2)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .hsel_i(hsel && sel == 2'd2), .haddr_i(haddr),
      .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst),
      .hready_i(hready), .hreadyout_o(rdy[2]), .hresp_o(rsp[2]), .hrdata_o(rd[2]),
      .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w,
                        input logic [2:0] s);
      hsel   = 1'b1;
      haddr  = a;
      htrans = t;
      hwrite = w;
      hsize  = s;
   endtask

   task automatic idle();
      hsel   = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
      hsize  = 3'b010;
   endtask

   // Two-cycle ERROR on responder 0 for one illegal address phase.
   task automatic err_seq(input string tag, input logic [31:0] a, input logic w,
                          input logic [2:0] s);
      drive(a, 2'b10, w, s);
      mid();
      tick();
      idle();
      mid();
      chk({tag, "_e1_resp"}, 32'(rsp[0]), 32'd1);
      chk({tag, "_e1_rdy"}, 32'(rdy[0]), 32'd0);
      tick();
      mid();
      chk({tag, "_e2_resp"}, 32'(rsp[0]), 32'd1);
      chk({tag, "_e2_rdy"}, 32'(rdy[0]), 32'd1);
      chk({tag, "_e2_data"}, rd[0], 32'h0);
      tick();
   endtask

   initial begin
      logic [31:0] words [4];
      words[0] = 32'h0000_0013;
      words[1] = 32'h0010_0093;
      words[2] = 32'h0020_0113;
      words[3] = 32'h0030_0193;

      // Reset values
      tick();
      mid();
      for (int k = 0; k < 3; k++) begin
         chk("rst_rdy", 32'(rdy[k]), 32'd1);
         chk("rst_resp", 32'(rsp[k]), 32'd0);
         chk("rst_data", rd[k], 32'h0);
      end
      tick();
      rst = 1'b0;

      for (int k = 0; k < 4; k++) begin
         load_en   = 1'b1;
         load_addr = 10'(k);
         load_data = words[k];
         tick();
      end
      load_en = 1'b0;

      // WAIT_STATES=0: pipelined burst, one word per cycle
      sel = 2'd0;
      drive(32'h0, 2'b10, 1'b0, 3'b010);
      mid();
      chk("b0_rdy_addr", 32'(rdy[0]), 32'd1);
      tick();
      for (int k = 1; k < 4; k++) begin
         drive(32'(k * 4), 2'b11, 1'b0, 3'b010);
         mid();
         chk("b0_data", rd[0], words[k-1]);
         chk("b0_rdy", 32'(rdy[0]), 32'd1);
         tick();
      end
      idle();
      mid();
      chk("b0_data_last", rd[0], words[3]);
      tick();
      mid();
      chk("b0_hold", rd[0], words[3]);
      tick();

      // WAIT_STATES=3: read 0x4
      sel = 2'd1;
      drive(32'h4, 2'b10, 1'b0, 3'b010);
      mid();
      tick();
      idle();
      for (int k = 0; k < 3; k++) begin
         mid();
         chk("ws3_wait_rdy", 32'(rdy[1]), 32'd0);
         chk("ws3_wait_data", rd[1], 32'h0);
         tick();
      end
      mid();
      chk("ws3_done_rdy", 32'(rdy[1]), 32'd1);
      chk("ws3_done_resp", 32'(rsp[1]), 32'd0);
      chk("ws3_done_data", rd[1], words[1]);
      tick();

      // Write is an error; read of 0x8 accepted in the ERR2 cycle
      sel = 2'd0;
      drive(32'h8, 2'b10, 1'b1, 3'b010);
      mid();
      tick();
      idle();
      mid();
      chk("wr_e1_resp", 32'(rsp[0]), 32'd1);
      chk("wr_e1_rdy", 32'(rdy[0]), 32'd0);
      tick();
      drive(32'h8, 2'b10, 1'b0, 3'b010);
      mid();
      chk("wr_e2_resp", 32'(rsp[0]), 32'd1);
      chk("wr_e2_rdy", 32'(rdy[0]), 32'd1);
      tick();
      idle();
      mid();
      chk("wr_after_data", rd[0], words[2]);
      chk("wr_after_resp", 32'(rsp[0]), 32'd0);
      tick();

      err_seq("misalign", 32'h2, 1'b0, 3'b010);
      err_seq("bytesz", 32'h0, 1'b0, 3'b000);
      err_seq("range", 32'h1000, 1'b0, 3'b010);

      // Read after error returns real data again
      drive(32'h0, 2'b10, 1'b0, 3'b010);
      mid();
      tick();
      idle();
      mid();
      chk("post_err_data", rd[0], words[0]);
      tick();

      // WAIT_STATES=2: backdoor load during WAIT does not disturb captured word
      sel = 2'd2;
      drive(32'hC, 2'b10, 1'b0, 3'b010);
      mid();
      tick();
      idle();
      load_en   = 1'b1;
      load_addr = 10'd3;
      load_data = 32'hDEAD_BEEF;
      mid();
      chk("ws2_w1_rdy", 32'(rdy[2]), 32'd0);
      tick();
      load_en = 1'b0;
      mid();
      chk("ws2_w2_rdy", 32'(rdy[2]), 32'd0);
      tick();
      drive(32'hC, 2'b10, 1'b0, 3'b010);
      mid();
      chk("ws2_old_rdy", 32'(rdy[2]), 32'd1);
      chk("ws2_old_data", rd[2], words[3]);
      tick();
      idle();
      mid();
      chk("ws2_hold", rd[2], words[3]);
      tick();
      mid();
      tick();
      mid();
      chk("ws2_new_rdy", 32'(rdy[2]), 32'd1);
      chk("ws2_new_data", rd[2], 32'hDEAD_BEEF);
      tick();

      // Reset while responder 1 is waiting
      sel = 2'd1;
      drive(32'h0, 2'b10, 1'b0, 3'b010);
      mid();
      tick();
      idle();
      mid();
      chk("rw_wait_rdy", 32'(rdy[1]), 32'd0);
      chk("rw_wait_data", rd[1], words[1]);
      tick();
      rst = 1'b1;
      #1;
      chk("rw_rst_rdy", 32'(rdy[1]), 32'd1);
      chk("rw_rst_resp", 32'(rsp[1]), 32'd0);
      chk("rw_rst_data", rd[1], 32'h0);
      tick();
      rst = 1'b0;
      tick();
      drive(32'h8, 2'b10, 1'b0, 3'b010);
      mid();
      tick();
      idle();
      for (int k = 0; k < 3; k++) begin
         mid();
         chk("rw_after_wait", 32'(rdy[1]), 32'd0);
         tick();
      end
      mid();
      chk("rw_after_rdy", 32'(rdy[1]), 32'd1);
      chk("rw_after_data", rd[1], words[2]);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ahb_imem_slave.md
# ahb_imem_slave

AHB-Lite read-only instruction memory responder serving the prefetch unit's AHB master. It decodes address phases, returns 32-bit instruction words with a configurable number of wait states, and issues two-cycle ERROR responses for illegal accesses. A backdoor load port fills the array before and during simulation or boot.

## Interface
- ADDR_WIDTH, 32, HADDR width (matches PC width)
- DATA_WIDTH, 32, HRDATA width (matches instruction width); only 32 supported
- DEPTH, 1024, memory depth in 32-bit words (power of two)
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- WAIT_STATES, 0, wait cycles inserted per read data phase (0..15)
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- hsel_i  in  1  slave select
- haddr_i  in  ADDR_WIDTH  transfer byte address
- htrans_i  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite_i  in  1  write request (always illegal)
- hsize_i  in  3  transfer size; only 3'b010 (word) legal
- hburst_i  in  3  burst type; accepted, not used
- hready_i  in  1  bus-wide HREADY from interconnect
- hreadyout_o  out  1  slave ready
- hresp_o  out  1  0=OKAY, 1=ERROR
- hrdata_o  out  DATA_WIDTH  read data
- load_en_i  in  1  backdoor word write
- load_addr_i  in  $clog2(DEPTH)  backdoor word index
- load_data_i  in  DATA_WIDTH  backdoor data

## Operation
- Address phase accepted when hsel_i & hready_i & htrans_i[1]; otherwise nothing sampled (IDLE/BUSY/unselected get zero-wait OKAY).
- Offset = haddr_i - BASE_ADDR (ADDR_WIDTH-bit, wraps); index = offset[ADDR_WIDTH-1:2].
- Illegal if any: hwrite_i=1, hsize_i!=3'b010, haddr_i[1:0]!=0, offset >= DEPTH*4. Illegal -> ERROR; memory never modified by bus.
- Legal read: array read at address phase; word captured in a data register, driven on hrdata_o when data phase completes.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: accepted legal, WAIT_STATES=0 -> IDLE (data next cycle, hreadyout_o=1); legal, WAIT_STATES>0 -> WAIT with counter=WAIT_STATES; illegal -> ERR1.
  - WAIT: hreadyout_o=0; counter decrements; at counter=1 -> IDLE (next cycle completes with data, hreadyout_o=1). No address sampled (hready_i low).
  - ERR1: hresp_o=1, hreadyout_o=0 -> ERR2.
  - ERR2: hresp_o=1, hreadyout_o=1; new address phase may be accepted here, next state per IDLE rules.
- hrdata_o holds its last value outside OKAY read completions; driven 0 on ERROR completion.
- Backdoor load writes array on the cycle load_en_i=1, independent of bus state. Same-cycle load and bus read of same word returns old data; a read already captured in WAIT returns captured (old) data.

## Timing
- Reset values: state IDLE, hreadyout_o=1, hresp_o=0, hrdata_o=0, counter=0; array contents not reset.
- Read latency: data phase = 1 + WAIT_STATES cycles after address phase; back-to-back pipelined reads at WAIT_STATES=0 give one word per cycle.
- Error: exactly 2 cycles, hresp_o high both, hreadyout_o low then high.
- Address phase on the completing data cycle (hready_i=1) is accepted; pipeline overlap is mandatory.
- Reset mid-transfer (WAIT/ERR1/ERR2): immediate return to reset values; pending transfer dropped.
- hsel_i deasserted during data phase does not abort it.

## Structure
- Shared package ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_WORD, HRESP_OKAY/ERROR, FSM state encoding; INST_WIDTH and PC width constants shared with the prefetch unit.
- Sub-module imem_ram_1r1w: DEPTH x DATA_WIDTH, synchronous read port (bus), synchronous write port (backdoor), read-old-data on collision.
- Top: address decode, FSM, wait counter, data register.

## Test plan
- Load words 0..3 = 0x00000013,0x00100093,0x00200113,0x00300193; WAIT_STATES=0; NONSEQ 0x0 then SEQ 0x4,0x8,0xC back-to-back -> hrdata_o those values on 4 consecutive cycles, hreadyout_o=1 throughout.
- WAIT_STATES=3; read 0x4 -> hreadyout_o low 3 cycles, then high with hrdata_o=0x00100093.
- Write NONSEQ to 0x8 -> hresp_o=1 two cycles, hreadyout_o 0 then 1; subsequent read 0x8 returns 0x00200113.
- Read 0x2 (misaligned), hsize=byte at 0x0, address DEPTH*4 -> each two-cycle ERROR, hrdata_o=0.
- WAIT_STATES=2; read 0xC, load word 3=0xDEADBEEF during WAIT -> returns 0x00300193; next read 0xC returns 0xDEADBEEF.
- Assert rst_i during WAIT -> hreadyout_o=1, hresp_o=0, hrdata_o=0 immediately; next read after release completes normally.
